// File: rtl/mod3_pkg.sv
// Shared types and the residue transition function for the serial mod-3 scheduler.
package mod3_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [1:0] residue_t;

  localparam residue_t RES0 = 2'd0;
  localparam residue_t RES1 = 2'd1;
  localparam residue_t RES2 = 2'd2;

  // Residue after appending bit b: (2*r + b) mod 3; the unused code 2'b11 recovers to 0.
  function automatic residue_t next_residue(residue_t r, logic b);
    case (r)
      RES0:    next_residue = b ? RES1 : RES0;
      RES1:    next_residue = b ? RES0 : RES2;
      RES2:    next_residue = b ? RES2 : RES1;
      default: next_residue = RES0;
    endcase
  endfunction

endpackage

// File: rtl/mod3_step.sv
// Registered mod-3 residue engine consuming one bit per enabled clock.
module mod3_step
  import mod3_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     en,
  input  logic     bit_in,
  output residue_t residue
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      residue <= RES0;
    end else if (en) begin
      residue <= next_residue(residue, bit_in);
    end
  end

endmodule

// File: rtl/mod3_serial_sched.sv
// Two-requester round-robin front end feeding words MSB-first into a shared mod-3 engine.
module mod3_serial_sched
  import mod3_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_div3,
  output logic [1:0]       res_rem,
  output logic             res_id,
  output logic             busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic             id;
  logic             last_grant;
  logic             grant0, grant1, accept;
  residue_t         residue;
  residue_t         held_rem;
  logic             held_div3;
  logic             held_id;

  // On contention the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
  assign accept = (state == IDLE) && (req0_valid || req1_valid);

  mod3_step u_step (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (state == SHIFT),
    .bit_in (shreg[WIDTH-1]),
    .residue(residue)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    res_valid  = (state == DONE);
    busy       = (state != IDLE);
    res_rem    = (state == DONE) ? residue : held_rem;
    res_div3   = (state == DONE) ? (residue == RES0) : held_div3;
    res_id     = (state == DONE) ? id : held_id;
  end

  // The held copies keep the result visible after the FSM leaves DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      count      <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      held_rem   <= RES0;
      held_div3  <= 1'b0;
      held_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= grant1 ? req1_data : req0_data;
            count <= CNT_W'(WIDTH);
            id    <= grant1;
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          count <= count - 1'b1;
        end
        DONE: begin
          held_rem  <= residue;
          held_div3 <= (residue == RES0);
          held_id   <= id;
          if (res_ready) last_grant <= id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod3_serial_sched.sv
// Scoreboard bench: requester drivers push expected results, a monitor checks the result port.
module tb_mod3_serial_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_data, req1_data;
  logic res_valid, res_ready, res_div3, res_id, busy;
  logic [1:0] res_rem;

  logic w1_reset = 1'b1;
  logic w1_valid = 1'b0, w1_data = 1'b0;
  logic w1_ready, w1_r1_ready, w1_res_valid, w1_div3, w1_id, w1_busy;
  logic [1:0] w1_rem;

  always #5 clk = ~clk;

  mod3_serial_sched #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_div3(res_div3),
    .res_rem(res_rem), .res_id(res_id), .busy(busy)
  );

  mod3_serial_sched #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset(w1_reset),
    .req0_valid(w1_valid), .req0_data(w1_data), .req0_ready(w1_ready),
    .req1_valid(1'b0), .req1_data(1'b0), .req1_ready(w1_r1_ready),
    .res_valid(w1_res_valid), .res_ready(1'b1), .res_div3(w1_div3),
    .res_rem(w1_rem), .res_id(w1_id), .busy(w1_busy)
  );

  typedef struct {
    logic       id;
    logic [1:0] rem;
    int         t;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  int rr_mode = 0;  // 0: res_ready high, 1: random, 2: low
  logic in_flight = 1'b0, inflight_id = 1'b0, last_served = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: abstract arbitration model decides who must be granted and predicts the result.
  initial begin : driver
    logic e0, e1, hs0, hs1;
    logic [W-1:0] d;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    forever begin
      @(negedge clk);
      hs0 = 1'b0; hs1 = 1'b0;
      if (reset) begin
        in_flight = 1'b0; last_served = 1'b1;
      end else begin
        e0 = !in_flight && req0_valid && (!req1_valid || last_served);
        e1 = !in_flight && req1_valid && (!req0_valid || !last_served);
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        hs0 = e0; hs1 = e1;
        if (hs0 || hs1) begin
          d = hs1 ? req1_data : req0_data;
          sb.push_back('{id: hs1, rem: 2'(int'(d) % 3), t: cyc});
          in_flight = 1'b1; inflight_id = hs1;
        end else if (in_flight && res_valid && res_ready) begin
          in_flight = 1'b0; last_served = inflight_id;
        end
      end
      @(posedge clk); #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      req0_valid = (q0.size() != 0);
      req1_valid = (q1.size() != 0);
      req0_data = req0_valid ? q0[0] : W'($urandom);
      req1_data = req1_valid ? q1[0] : W'($urandom);
    end
  end

  initial begin : ready_gen
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin : monitor
    exp_t e, last;
    logic have_last = 1'b0, prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete(); have_last = 1'b0;
      end else if (res_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_res_valid", res_valid, 0);
        end else begin
          e = sb[0];
          check("res_rem", res_rem, e.rem);
          check("res_div3", res_div3, e.rem == 2'd0);
          check("res_id", res_id, e.id);
          if (!prev_valid) check("latency", cyc - e.t, W + 1);
          if (res_ready) begin
            last = sb.pop_front(); have_last = 1'b1;
          end
        end
      end else if (have_last) begin
        check("held_rem", res_rem, last.rem);
        check("held_div3", res_div3, last.rem == 2'd0);
        check("held_id", res_id, last.id);
      end
      prev_valid = res_valid && !reset;
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || in_flight || sb.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("drain_timeout", n >= 3000, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_res_rem", res_rem, 0);
    check("rst_res_div3", res_div3, 0);
    check("rst_res_id", res_id, 0);
    @(posedge clk); #1 reset = 1'b0;

    q0.push_back(8'd9);
    wait_drain();
    q1.push_back(8'd255); q1.push_back(8'd7); q1.push_back(8'd200);
    wait_drain();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(8'd3); q1.push_back(8'd4);
    end
    wait_drain();

    // Long stall in DONE, then release.
    q0.push_back(8'd44); q1.push_back(8'd91);
    rr_mode = 2;
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    check("stall_wait_timeout", n >= 100, 0);
    repeat (5) @(negedge clk);
    rr_mode = 0;
    wait_drain();

    // Reset during the 4th SHIFT cycle discards the word.
    q0.push_back(8'd100);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 100);
    check("busy_wait_timeout", n >= 100, 0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_res_valid", res_valid, 0);
    repeat (W + 3) begin
      @(negedge clk);
      check("midrst_no_result", res_valid, 0);
    end
    q0.push_back(8'd6);
    wait_drain();

    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1)) q0.push_back(W'($urandom));
      if ($urandom_range(0, 1)) q1.push_back(W'($urandom));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    q0.push_back('0); q1.push_back('1);
    wait_drain();
    rr_mode = 0;

    @(posedge clk); #1 w1_reset = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1; w1_valid = 1'b1; w1_data = b[0];
      @(negedge clk); check("w1_ready", w1_ready, 1);
      @(posedge clk); #1; w1_valid = 1'b0;
      @(negedge clk); check("w1_early_valid", w1_res_valid, 0);
      @(negedge clk);
      check("w1_res_valid", w1_res_valid, 1);
      check("w1_div3", w1_div3, b == 0);
      check("w1_rem", w1_rem, b);
      check("w1_id", w1_id, 0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
